// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO memory map and its flag channels.
package mmio_pkg;

    // MMIO registers sit on 256-byte boundaries; addr[11:8] is the register index.
    localparam int MMIO_STRIDE_LOG2 = 8;

    // Bit positions inside a channel flag register.
    localparam int FLAG_BUSY = 0;
    localparam int FLAG_DONE = 1;

    // Default roles of the general config registers.
    localparam int MATMUL_A_IDX    = 0;
    localparam int MATMUL_B_IDX    = 1;
    localparam int MATMUL_C_IDX    = 2;
    localparam int MATMUL_DIM_IDX  = 3;
    localparam int MATVEC_A_IDX    = 4;
    localparam int MATVEC_X_IDX    = 5;
    localparam int MATVEC_Y_IDX    = 6;
    localparam int MAXPOOL_SRC_IDX = 7;
    localparam int MAXPOOL_DST_IDX = 8;
    localparam int BIAS_ADDR_IDX   = 9;

    // Per-channel flag state.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } flag_state_e;

endpackage

// File: rtl/mmio_flag_ch.sv
// One accelerator channel: busy/done flag state machine plus a one-cycle start pulse.
module mmio_flag_ch
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [1:0] i_wdata,
    input  logic       i_done,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_start,
    output logic       o_drop
);

    flag_state_e r_state;
    flag_state_e w_state_next;
    logic        r_done;
    logic        w_done_next;
    logic        r_start;
    logic        w_start_next;

    // State, sticky done bit and start pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_start <= w_start_next;
        end
    end

    // Next-state logic; a software write while busy is rejected and reported as dropped.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = r_done;
        w_start_next = 1'b0;
        o_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_we) begin
                    if (i_wdata[FLAG_BUSY]) begin
                        w_state_next = BUSY;
                        w_done_next  = 1'b0;
                        w_start_next = 1'b1;
                    end else begin
                        w_done_next = i_wdata[FLAG_DONE];
                    end
                end
            end
            BUSY: begin
                if (i_done) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
                if (i_we) begin
                    o_drop = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy  = (r_state == BUSY);
    assign o_done  = r_done;
    assign o_start = r_start;

endmodule

// File: rtl/sram.sv
// True dual-port word RAM with registered, old-data reads; port A wins a same-address write clash.
module sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_a,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_q_a;
    logic [DATA_WIDTH-1:0] r_q_b;

    // Writes (B first so A overrides on a clash) and registered reads of the previous contents.
    always_ff @(posedge clk) begin
        if (we_b) begin
            r_mem[addr_b] <= data_b;
        end
        if (we_a) begin
            r_mem[addr_a] <= data_a;
        end
        r_q_a <= r_mem[addr_a];
        r_q_b <= r_mem[addr_b];
    end

    assign q_a = r_q_a;
    assign q_b = r_q_b;

endmodule

// File: rtl/mmio_mem_map.sv
// Dual-port memory map: MMIO config registers and channel flags in the low window, SRAM elsewhere.
module mmio_mem_map
    import mmio_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_REGS        = 10,
    parameter int NUM_CH          = 4,
    parameter int MMIO_TOP_BIT    = 12,
    parameter int SRAM_WORDS_LOG2 = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          addr_a,
    input  logic [ADDR_WIDTH-1:0]          addr_b,
    input  logic [DATA_WIDTH-1:0]          data_a,
    input  logic [DATA_WIDTH-1:0]          data_b,
    input  logic                           we_a,
    input  logic                           we_b,
    output logic [DATA_WIDTH-1:0]          q_a,
    output logic [DATA_WIDTH-1:0]          q_b,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_o,
    output logic [NUM_CH-1:0]              start_o,
    input  logic [NUM_CH-1:0]              done_i,
    output logic [NUM_CH-1:0]              busy_o,
    output logic                           err_o
);

    localparam int IDX_W = MMIO_TOP_BIT - MMIO_STRIDE_LOG2;

    logic                  w_mmio_a, w_mmio_b;
    logic [IDX_W-1:0]      w_idx_a, w_idx_b;
    logic [NUM_REGS-1:0]   w_cfg_sel_a, w_cfg_sel_b;
    logic [NUM_CH-1:0]     w_flag_sel_a, w_flag_sel_b;
    logic [NUM_CH-1:0]     w_flag_done, w_flag_drop;
    logic                  w_unmapped_a, w_unmapped_b;
    logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;
    logic [DATA_WIDTH-1:0] w_sram_q_a, w_sram_q_b;
    logic [DATA_WIDTH-1:0] r_rd_a, r_rd_b;
    logic                  r_sel_sram_a, r_sel_sram_b;
    logic                  r_err;

    // Address decode: MMIO only on register-aligned addresses inside the low window.
    assign w_mmio_a = (addr_a[ADDR_WIDTH-1:MMIO_TOP_BIT] == '0) && (addr_a[MMIO_STRIDE_LOG2-1:0] == '0);
    assign w_mmio_b = (addr_b[ADDR_WIDTH-1:MMIO_TOP_BIT] == '0) && (addr_b[MMIO_STRIDE_LOG2-1:0] == '0);
    assign w_idx_a  = addr_a[MMIO_TOP_BIT-1:MMIO_STRIDE_LOG2];
    assign w_idx_b  = addr_b[MMIO_TOP_BIT-1:MMIO_STRIDE_LOG2];

    // Config registers; port A takes precedence when both ports write the same one.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
        logic [DATA_WIDTH-1:0] r_cfg;
        assign w_cfg_sel_a[gi] = w_mmio_a && (w_idx_a == IDX_W'(gi));
        assign w_cfg_sel_b[gi] = w_mmio_b && (w_idx_b == IDX_W'(gi));

        // Register update with A-over-B priority.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cfg <= '0;
            end else if (w_cfg_sel_a[gi] && we_a) begin
                r_cfg <= data_a;
            end else if (w_cfg_sel_b[gi] && we_b) begin
                r_cfg <= data_b;
            end
        end
        assign cfg_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_cfg;
    end

    // One flag state machine per accelerator channel, placed right after the config registers.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic       w_wr_a, w_wr_b;
        logic [1:0] w_wdata;
        assign w_flag_sel_a[gi] = w_mmio_a && (w_idx_a == IDX_W'(NUM_REGS + gi));
        assign w_flag_sel_b[gi] = w_mmio_b && (w_idx_b == IDX_W'(NUM_REGS + gi));
        assign w_wr_a  = w_flag_sel_a[gi] && we_a;
        assign w_wr_b  = w_flag_sel_b[gi] && we_b;
        assign w_wdata = w_wr_a ? data_a[1:0] : data_b[1:0];

        mmio_flag_ch u_flag (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wr_a || w_wr_b),
            .i_wdata (w_wdata),
            .i_done  (done_i[gi]),
            .o_busy  (busy_o[gi]),
            .o_done  (w_flag_done[gi]),
            .o_start (start_o[gi]),
            .o_drop  (w_flag_drop[gi])
        );
    end

    assign w_unmapped_a = w_mmio_a && !(|w_cfg_sel_a) && !(|w_flag_sel_a);
    assign w_unmapped_b = w_mmio_b && !(|w_cfg_sel_b) && !(|w_flag_sel_b);

    // MMIO read mux for both ports; unmapped and SRAM addresses yield zero here.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int c = 0; c < NUM_REGS; c++) begin
            if (w_cfg_sel_a[c]) w_rd_a = cfg_o[c*DATA_WIDTH +: DATA_WIDTH];
            if (w_cfg_sel_b[c]) w_rd_b = cfg_o[c*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_flag_sel_a[c]) begin
                w_rd_a[FLAG_BUSY] = busy_o[c];
                w_rd_a[FLAG_DONE] = w_flag_done[c];
            end
            if (w_flag_sel_b[c]) begin
                w_rd_b[FLAG_BUSY] = busy_o[c];
                w_rd_b[FLAG_DONE] = w_flag_done[c];
            end
        end
    end

    // Read pipeline stage for MMIO data and region select, plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_a       <= '0;
            r_rd_b       <= '0;
            r_sel_sram_a <= 1'b0;
            r_sel_sram_b <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_a       <= w_rd_a;
            r_rd_b       <= w_rd_b;
            r_sel_sram_a <= !w_mmio_a;
            r_sel_sram_b <= !w_mmio_b;
            r_err        <= r_err || w_unmapped_a || w_unmapped_b || (|w_flag_drop);
        end
    end

    sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (SRAM_WORDS_LOG2)
    ) u_sram (
        .clk    (clk),
        .addr_a (addr_a[SRAM_WORDS_LOG2+1:2]),
        .addr_b (addr_b[SRAM_WORDS_LOG2+1:2]),
        .data_a (data_a),
        .data_b (data_b),
        .we_a   (we_a && !w_mmio_a),
        .we_b   (we_b && !w_mmio_b),
        .q_a    (w_sram_q_a),
        .q_b    (w_sram_q_b)
    );

    assign q_a   = r_sel_sram_a ? w_sram_q_a : r_rd_a;
    assign q_b   = r_sel_sram_b ? w_sram_q_b : r_rd_b;
    assign err_o = r_err;

endmodule

// File: tb/tb_mmio_mem_map.sv
// Scoreboard bench for mmio_mem_map: read expectations are queued when issued and checked one cycle later.
module tb_mmio_mem_map;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 10;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic          we_a, we_b;
    logic [DW-1:0] q_a, q_b;
    logic [NR*DW-1:0] cfg_o;
    logic [NC-1:0] start_o, done_i, busy_o;
    logic          err_o;

    mmio_mem_map dut (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .data_a  (data_a),
        .data_b  (data_b),
        .we_a    (we_a),
        .we_b    (we_b),
        .q_a     (q_a),
        .q_b     (q_b),
        .cfg_o   (cfg_o),
        .start_o (start_o),
        .done_i  (done_i),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          port_b;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] m_cfg [NR];
    logic [31:0] m_sram [int];
    int          wr_addrs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        addr_a = '0; data_a = '0; we_a = 1'b0;
        addr_b = '0; data_b = '0; we_b = 1'b0;
        done_i = '0;
    endtask

    // Advance one clock, then compare every read result that has come due.
    task automatic tick();
        exp_t e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e   = exp_q.pop_front();
            obs = e.port_b ? q_b : q_a;
            $display("txn %s port=%s q=%h", e.tag, e.port_b ? "B" : "A", obs);
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic push_exp(input bit pb, input logic [31:0] v, input string tag);
        exp_t e;
        e.due = cyc + 1; e.port_b = pb; e.val = v; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
        addr_a = a; data_a = d; we_a = 1'b1;
    endtask

    task automatic wr_b(input logic [31:0] a, input logic [31:0] d);
        addr_b = a; data_b = d; we_b = 1'b1;
    endtask

    task automatic rd_a(input logic [31:0] a, input logic [31:0] v, input string tag);
        addr_a = a; we_a = 1'b0; push_exp(1'b0, v, tag);
    endtask

    task automatic rd_b(input logic [31:0] a, input logic [31:0] v, input string tag);
        addr_b = a; we_b = 1'b0; push_exp(1'b1, v, tag);
    endtask

    task automatic chk_cfg_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s_cfg%0d", tag, i), cfg_o[i*DW +: DW], m_cfg[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) m_cfg[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        idle();
        for (int i = 0; i < NR; i++) m_cfg[i] = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_q_a", q_a, 32'h0);
        chk("rst_q_b", q_b, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_start", 32'(start_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk_cfg_all("rst");
        rst = 1'b0;

        // Config register write/read, then read-during-write returns the old value.
        wr_a(32'h600, 32'h1234); tick(); idle(); m_cfg[6] = 32'h1234;
        chk("cfg6_write", cfg_o[6*DW +: DW], m_cfg[6]);
        rd_b(32'h600, 32'h1234, "rd_b_600"); tick(); idle();
        wr_a(32'h600, 32'h5555); rd_b(32'h600, 32'h1234, "rdw_old"); tick(); idle();
        m_cfg[6] = 32'h5555;
        rd_b(32'h600, 32'h5555, "rd_new"); tick(); idle();

        // SRAM path, including an unaligned address inside the low window.
        wr_a(32'h2000, 32'hDEAD); tick(); idle();
        rd_a(32'h2000, 32'hDEAD, "sram_2000"); tick(); idle();
        wr_b(32'h4, 32'hCAFE); tick(); idle();
        rd_a(32'h4, 32'hCAFE, "sram_004"); tick(); idle();
        chk_cfg_all("after_sram");

        // Both ports write the same register: A wins.
        wr_a(32'h100, 32'd5); wr_b(32'h100, 32'd9); tick(); idle(); m_cfg[1] = 32'd5;
        rd_a(32'h100, 32'd5, "conflict_rd"); tick(); idle();
        chk("conflict_cfg1", cfg_o[1*DW +: DW], m_cfg[1]);

        // Channel 0: start pulse, dropped write while busy, done handshake.
        wr_a(32'hA00, 32'h1); tick(); idle();
        chk("ch0_start", 32'(start_o), 32'h1);
        chk("ch0_busy", 32'(busy_o), 32'h1);
        tick();
        chk("ch0_start_once", 32'(start_o), 32'h0);
        chk("ch0_err_clean", 32'(err_o), 32'h0);
        wr_a(32'hA00, 32'h1); tick(); idle();
        chk("ch0_no_restart", 32'(start_o), 32'h0);
        chk("ch0_drop_err", 32'(err_o), 32'h1);
        rd_b(32'hA00, 32'h1, "ch0_flag_busy"); tick(); idle();
        done_i = 4'b0001; tick(); idle();
        chk("ch0_idle", 32'(busy_o), 32'h0);
        rd_a(32'hA00, 32'h2, "ch0_flag_done"); tick(); idle();
        wr_b(32'hA00, 32'h1); tick(); idle();
        rd_b(32'hA00, 32'h1, "ch0_done_cleared"); tick(); idle();
        done_i = 4'b0001; tick(); idle();

        do_reset();
        chk("rst2_err", 32'(err_o), 32'h0);
        chk("rst2_cfg1", cfg_o[1*DW +: DW], m_cfg[1]);

        // Channel 1: done coincident with a software write while busy.
        wr_a(32'hB00, 32'h1); tick(); idle();
        done_i = 4'b0010; wr_a(32'hB00, 32'h1); tick(); idle();
        chk("ch1_busy", 32'(busy_o), 32'h0);
        chk("ch1_no_start", 32'(start_o), 32'h0);
        chk("ch1_err", 32'(err_o), 32'h1);
        rd_a(32'hB00, 32'h2, "ch1_flag_done"); tick(); idle();
        wr_b(32'hB00, 32'h0); tick(); idle();
        rd_b(32'hB00, 32'h0, "ch1_cleared"); tick(); idle();
        wr_a(32'hB00, 32'hFFFF_FFF2); tick(); idle();
        rd_a(32'hB00, 32'h2, "ch1_set_done"); tick(); idle();
        chk("ch1_still_idle", 32'(busy_o), 32'h0);

        // Channel 3: done while idle is ignored; flag write conflict resolved to A.
        done_i = 4'b1000; tick(); idle();
        rd_a(32'hD00, 32'h0, "ch3_done_ignored"); tick(); idle();
        wr_a(32'hD00, 32'h0); wr_b(32'hD00, 32'h1); tick(); idle();
        chk("ch3_conflict_start", 32'(start_o), 32'h0);
        chk("ch3_conflict_busy", 32'(busy_o), 32'h0);

        do_reset();
        chk("rst3_err", 32'(err_o), 32'h0);

        // Unmapped MMIO indices.
        rd_a(32'hF00, 32'h0, "unmapped_f00"); tick(); idle();
        chk("unmapped_err", 32'(err_o), 32'h1);
        wr_b(32'hE00, 32'h1); tick(); idle();
        rd_b(32'hE00, 32'h0, "unmapped_e00"); tick(); idle();
        chk("unmapped_no_start", 32'(start_o), 32'h0);

        // Reset coincident with a start request, then reset while busy.
        wr_a(32'hC00, 32'h1); rst = 1'b1; tick(); rst = 1'b0; idle();
        chk("ch2_rst_start", 32'(start_o), 32'h0);
        chk("ch2_rst_busy", 32'(busy_o), 32'h0);
        wr_a(32'hC00, 32'h1); tick(); idle();
        chk("ch2_busy", 32'(busy_o), 32'h4);
        wr_a(32'h300, 32'h77); tick(); idle();
        addr_a = 32'h300; addr_b = 32'h300;
        push_exp(1'b0, 32'h0, "rst_mid_q_a");
        push_exp(1'b1, 32'h0, "rst_mid_q_b");
        rst = 1'b1; tick(); rst = 1'b0; idle();
        for (int i = 0; i < NR; i++) m_cfg[i] = '0;
        chk("rst_mid_busy", 32'(busy_o), 32'h0);
        chk("rst_mid_start", 32'(start_o), 32'h0);
        tick();
        chk("rst_mid_no_start", 32'(start_o), 32'h0);
        chk_cfg_all("rst_mid");

        // Random SRAM traffic on alternating ports, read back pipelined.
        for (int i = 0; i < 16; i++) begin
            a = 32'h1000 + 4 * $urandom_range(0, 255);
            d = $urandom;
            if (i % 2 == 0) wr_a(a, d); else wr_b(a, d);
            m_sram[int'(a)] = d;
            wr_addrs.push_back(int'(a));
            tick(); idle();
        end
        for (int i = 0; i < wr_addrs.size(); i++) begin
            a = wr_addrs[i];
            if (i % 2 == 0) rd_b(a, m_sram[int'(a)], $sformatf("sram_rand%0d", i));
            else            rd_a(a, m_sram[int'(a)], $sformatf("sram_rand%0d", i));
            tick(); idle();
        end
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
